hazard_ctrl: RTL

- Pipeline control unit for the 16-bit 5-stage CPU.
- Sequences the IF/ID and ID/EX pipeline registers and the PC.
- Generates PC write-enable, IF/ID write/flush and ID/EX bubble from three sources: load-use hazards, taken branches resolved in EX, and instruction-memory wait states.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/cpu_pipe_pkg.sv | 15 +
 rtl/hazard_ctrl_sat_cnt.sv | 30 +++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the 16-bit 5-stage CPU.
// Holds the control FSM state encoding and register/NOP constants.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam int REG_AW_DEF = 4;
  localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;
  localparam logic [15:0] NOP_INSN = 16'h0000;

endpackage

// File: rtl/hazard_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control: PC/IF-ID/ID-EX sequencing for load-use,
// taken-branch flush and imem wait states, plus perf counters.
module hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_rs1_used,
  input  logic              ifid_rs2_used,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              branch_taken,
  input  logic              imem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles
);

  localparam logic [1:0] FCNT_LOAD = 2'(BR_PENALTY - 1);

  state_e     state_q;
  state_e     state_d;
  logic [1:0] fcnt_q;
  logic [1:0] fcnt_d;
  logic       lu;
  logic       wait_lu;

  assign lu = idex_memread
           && (idex_rd != REG_AW'(REG_ZERO))
           && ((idex_rd == ifid_rs1 && ifid_rs1_used)
            || (idex_rd == ifid_rs2 && ifid_rs2_used));

  assign wait_lu = (state_q == S_WAIT) && !imem_ready;

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    if (rst) begin
      state_d = S_RUN;
      fcnt_d  = 2'd0;
    end else if (branch_taken) begin
      pc_write = 1'b1;
      // a redirect while imem is still busy keeps waiting
      if (wait_lu) begin
        state_d = S_WAIT;
      end else if (BR_PENALTY > 1) begin
        state_d = S_FLUSH;
        fcnt_d  = FCNT_LOAD;
      end else begin
        state_d = imem_ready ? S_RUN : S_WAIT;
      end
    end else begin
      case (state_q)
        S_FLUSH: begin
          pc_write    = imem_ready;
          idex_bubble = 1'b0;
          if (fcnt_q == 2'd1) begin
            state_d = imem_ready ? S_RUN : S_WAIT;
            fcnt_d  = 2'd0;
          end else begin
            fcnt_d = fcnt_q - 2'd1;
          end
        end
        S_RUN, S_WAIT: begin
          if (lu) begin
            ifid_flush = wait_lu;
            state_d    = wait_lu ? S_WAIT : S_RUN;
          end else if (!imem_ready) begin
            idex_bubble = 1'b0;
            state_d     = S_WAIT;
          end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            state_d     = S_RUN;
          end
        end
        default: begin
          state_d = S_RUN;
          fcnt_d  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    fcnt_q  <= fcnt_d;
  end

  sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (!pc_write),
    .cnt   (stall_cycles)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (branch_taken || state_q == S_FLUSH),
    .cnt   (flush_cycles)
  );

endmodule
